volt_seg_disp: RTL and testbench
================================

VOLT_SEG_DISP -- requirements
Module: volt_seg_disp

Interface
REQ-001 SHALL have parameter CNT_SCAN_MAX, default 49999; scan period per digit minus 1, in sys_clk cycles (1 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_UPD_MAX, default 24999999; display update period minus 1, in sys_clk cycles (0.5 s); legal values >= 20.
REQ-003 SHALL have port sys_clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port volt  input  16  unsigned voltage magnitude from the ADC stage, unit 1 mV.
REQ-006 SHALL have port sign  input  1  polarity from the ADC stage, 1 = negative.
REQ-007 SHALL have port sel  output  6  one-hot digit select, active-high, sel[0] = rightmost digit.
REQ-008 SHALL have port seg  output  8  segment pattern, common-anode, active-low, seg[7] = dp, seg[6:0] = g..a.

Function
REQ-009 SHALL run a free update counter 0..CNT_UPD_MAX, wrapping to 0; an update tick is the cycle where it equals CNT_UPD_MAX.
REQ-010 SHALL implement FSM states IDLE and CONV.
REQ-011 SHALL, on an update tick in IDLE, latch volt and sign, clear a 20-bit BCD accumulator, and enter CONV.
REQ-012 SHALL, in CONV, perform one double-dabble step per cycle: each BCD nibble >= 5 gets +3, then shift {BCD, binary} left by one bit.
REQ-013 SHALL remain in CONV for exactly 16 cycles, then, on the 16th CONV edge, load the 5 BCD digits and the latched sign into display registers and return to IDLE.
REQ-014 SHALL make display registers change exactly 17 sys_clk edges after the tick edge; between updates, the display is held constant.
REQ-015 SHALL ignore volt and sign changes after latching and ignore update ticks while in CONV.
REQ-016 SHALL run a scan counter 0..CNT_SCAN_MAX; when it equals CNT_SCAN_MAX, it wraps to 0 and the digit index advances 0->1->...->5->0.
REQ-017 SHALL drive sel and seg from registers updated on the same edge, so that seg always corresponds to the digit currently selected by sel.
REQ-018 SHALL map digit indices 0..3 to BCD digits units, tens, hundreds, and thousands of mV.
REQ-019 SHALL display digit index 3 with dp lit (seg[7]=0), giving the format X.XXX V.
REQ-020 SHALL map digit index 4 to the ten-thousands BCD digit, blanked (8'hFF) when it is zero.
REQ-021 SHALL drive digit index 5 as minus (8'hBF) when the displayed sign = 1 and the displayed value is nonzero, and otherwise blank (8'hFF).
REQ-022 SHALL use the decode table 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 (hex, dp off); dp on clears bit 7.
REQ-023 SHALL display volt = 0 as "  0.000" with no minus, regardless of sign.
REQ-024 SHALL display volt = 65535 (maximum) as "65.535" with no overflow handling.

Reset
REQ-025 SHALL, while sys_rst_n = 0, force sel=6'b000001, seg=8'hFF, FSM=IDLE, all counters, BCD, and display registers = 0, and the displayed sign = 0.
REQ-026 SHALL, after reset release, show blank/zero content ("0.000" pattern on digits 0..3) until the first update tick plus 17 cycles.
REQ-027 SHALL, on reset asserted mid-CONV, abort the conversion with no partial result reaching the display.

Verification (CNT_SCAN_MAX=3, CNT_UPD_MAX=39)
REQ-028 SHALL cover: volt=1234, sign=0, run one full scan after the update -> digits0..5 seg = 99,B0,A4,79,FF,FF.
REQ-029 SHALL cover: volt=5000, sign=1 -> digit3=12 (5 with dp), digits2..0=C0, digit4=FF, digit5=BF.
REQ-030 SHALL cover: volt=0, sign=1 -> digit5=FF, digit3=40, digits2..0=C0.
REQ-031 SHALL cover: volt=65535 -> digits0..4 = 92,B0,92,12,82.
REQ-032 SHALL cover: volt changed from 1234 to 4321 on the cycle after the tick -> display shows 1.234 until the next update.
REQ-033 SHALL cover: sys_rst_n pulsed low 8 cycles after the tick -> sel=000001, seg=FF immediately, and the display remains zero until the next full conversion.

Source files
------------

// File: rtl/volt_seg_disp.sv
// Six-digit seven-segment voltmeter display: latches the ADC reading periodically, converts it
// to BCD with a serial double-dabble, and scans it out as "-XX.XXX" on a common-anode display.
module volt_seg_disp #(
   parameter int unsigned CNT_SCAN_MAX = 49999,
   parameter int unsigned CNT_UPD_MAX  = 24999999
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [15:0] volt,
   input  logic        sign,
   output logic [5:0]  sel,
   output logic [7:0]  seg
);

   localparam int unsigned UPD_W  = $clog2(CNT_UPD_MAX + 1);
   localparam int unsigned SCAN_W = $clog2(CNT_SCAN_MAX + 1);

   typedef enum logic {IDLE, CONV} state_t;

   state_t              state_q, state_d;
   logic [UPD_W-1:0]    upd_cnt_q, upd_cnt_d;
   logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
   logic [2:0]          idx_q, idx_d;
   logic [15:0]         bin_q, bin_d;
   logic                sign_lat_q, sign_lat_d;
   logic [19:0]         bcd_q, bcd_d;
   logic [3:0]          step_q, step_d;
   logic [19:0]         dsp_bcd_q, dsp_bcd_d;
   logic                dsp_sign_q, dsp_sign_d;
   logic [5:0]          sel_q, sel_d;
   logic [7:0]          seg_q, seg_d;
   logic [19:0]         adj;
   logic                tick;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] p;
      case (d)
         4'd0:    p = 8'hC0;
         4'd1:    p = 8'hF9;
         4'd2:    p = 8'hA4;
         4'd3:    p = 8'hB0;
         4'd4:    p = 8'h99;
         4'd5:    p = 8'h92;
         4'd6:    p = 8'h82;
         4'd7:    p = 8'hF8;
         4'd8:    p = 8'h80;
         4'd9:    p = 8'h90;
         default: p = 8'hFF;
      endcase
      return p;
   endfunction

   assign tick = (upd_cnt_q == UPD_W'(CNT_UPD_MAX));

   always_comb begin
      state_d    = state_q;
      upd_cnt_d  = tick ? '0 : upd_cnt_q + UPD_W'(1);
      scan_cnt_d = scan_cnt_q;
      idx_d      = idx_q;
      bin_d      = bin_q;
      sign_lat_d = sign_lat_q;
      bcd_d      = bcd_q;
      step_d     = step_q;
      dsp_bcd_d  = dsp_bcd_q;
      dsp_sign_d = dsp_sign_q;
      adj        = bcd_q;

      case (state_q)
         IDLE: begin
            if (tick) begin
               bin_d      = volt;
               sign_lat_d = sign;
               bcd_d      = '0;
               step_d     = '0;
               state_d    = CONV;
            end
         end
         CONV: begin
            for (int unsigned i = 0; i < 5; i++) begin
               if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
            {bcd_d, bin_d} = {adj[18:0], bin_q, 1'b0};
            step_d = step_q + 4'd1;
            if (step_q == 4'd15) begin
               dsp_bcd_d  = {adj[18:0], bin_q[15]};
               dsp_sign_d = sign_lat_q;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (scan_cnt_q == SCAN_W'(CNT_SCAN_MAX)) begin
         scan_cnt_d = '0;
         idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
         scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      end

      // Pattern is built from the next-cycle digit and display contents so seg never lags sel
      sel_d = 6'b000001 << idx_d;
      case (idx_d)
         3'd0:    seg_d = seg7(dsp_bcd_d[3:0]);
         3'd1:    seg_d = seg7(dsp_bcd_d[7:4]);
         3'd2:    seg_d = seg7(dsp_bcd_d[11:8]);
         3'd3:    seg_d = seg7(dsp_bcd_d[15:12]) & 8'h7F;
         3'd4:    seg_d = (dsp_bcd_d[19:16] == 4'd0) ? 8'hFF : seg7(dsp_bcd_d[19:16]);
         3'd5:    seg_d = (dsp_sign_d && (dsp_bcd_d != '0)) ? 8'hBF : 8'hFF;
         default: seg_d = 8'hFF;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         upd_cnt_q  <= '0;
         scan_cnt_q <= '0;
         idx_q      <= '0;
         bin_q      <= '0;
         sign_lat_q <= 1'b0;
         bcd_q      <= '0;
         step_q     <= '0;
         dsp_bcd_q  <= '0;
         dsp_sign_q <= 1'b0;
         sel_q      <= 6'b000001;
         seg_q      <= 8'hFF;
      end else begin
         state_q    <= state_d;
         upd_cnt_q  <= upd_cnt_d;
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         bin_q      <= bin_d;
         sign_lat_q <= sign_lat_d;
         bcd_q      <= bcd_d;
         step_q     <= step_d;
         dsp_bcd_q  <= dsp_bcd_d;
         dsp_sign_q <= dsp_sign_d;
         sel_q      <= sel_d;
         seg_q      <= seg_d;
      end
   end

   assign sel = sel_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_volt_seg_disp.sv
// Bench for volt_seg_disp: cycle-level behavioural model of the displayed voltage, compared
// on every falling edge, plus literal digit-pattern expectations for fixed readings.
module tb_volt_seg_disp;

   localparam int SCAN = 3;
   localparam int UPD  = 39;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [15:0] volt      = '0;
   logic        sign      = 1'b0;
   logic [5:0]  sel;
   logic [7:0]  seg;

   volt_seg_disp #(.CNT_SCAN_MAX(SCAN), .CNT_UPD_MAX(UPD)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .volt      (volt),
      .sign      (sign),
      .sel       (sel),
      .seg       (seg)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Model state: the value on the display, a pending captured reading, and the scan position
   logic [7:0] dec_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   int m_upd = 0, m_scan = 0, m_idx = 0, m_left = 0;
   bit m_busy = 0, m_started = 0;
   int m_cap_val = 0;
   bit m_cap_sign = 0;
   int m_val = 0;
   bit m_sgn = 0;
   int m_updates = 0;

   function automatic logic [7:0] model_seg(int idx, int val, bit sg);
      int pw [5] = '{1, 10, 100, 1000, 10000};
      int dig;
      dig = (idx < 5) ? (val / pw[idx]) % 10 : 0;
      case (idx)
         0, 1, 2: return dec_tab[dig];
         3:       return dec_tab[dig] & 8'h7F;
         4:       return (dig == 0) ? 8'hFF : dec_tab[dig];
         default: return (sg && val != 0) ? 8'hBF : 8'hFF;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge sys_clk or negedge sys_rst_n);
         if (!sys_rst_n) begin
            m_upd = 0; m_scan = 0; m_idx = 0; m_left = 0;
            m_busy = 0; m_started = 0; m_val = 0; m_sgn = 0;
         end else begin
            bit tick;
            tick = (m_upd == UPD);
            if (m_busy) begin
               m_left--;
               if (m_left == 0) begin
                  m_val = m_cap_val; m_sgn = m_cap_sign; m_busy = 0; m_updates++;
               end
            end else if (tick) begin
               m_cap_val = int'(volt); m_cap_sign = sign; m_busy = 1; m_left = 16;
            end
            m_upd = tick ? 0 : m_upd + 1;
            if (m_scan == SCAN) begin
               m_scan = 0; m_idx = (m_idx + 1) % 6;
            end else m_scan++;
            m_started = 1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge sys_clk);
         if (!m_started) begin
            check("sel", 32'(sel), 32'h01);
            check("seg", 32'(seg), 32'hFF);
         end else begin
            check("sel", 32'(sel), 32'(6'b000001 << m_idx));
            check("seg", 32'(seg), 32'(model_seg(m_idx, m_val, m_sgn)));
         end
      end
   end

   task automatic wait_update();
      int u;
      bit ok;
      u = m_updates;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (m_updates != u) begin ok = 1; break; end
      end
      check("update_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_latch();
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (!m_busy) begin ok = 1; break; end
      end
      check("idle_timeout", 32'(ok), 32'd1);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (m_busy) begin ok = 1; break; end
      end
      check("latch_timeout", 32'(ok), 32'd1);
   endtask

   task automatic apply_and_wait(input int v, input bit s);
      volt = 16'(v);
      sign = s;
      if (m_busy) wait_update();
      wait_update();
   endtask

   // exp holds {digit5, digit4, ..., digit0}
   task automatic capture_digits(input string nm, input logic [47:0] exp);
      logic [7:0] cap [6];
      for (int i = 0; i < 6; i++) cap[i] = 8'hxx;
      for (int c = 0; c < 28; c++) begin
         @(negedge sys_clk);
         for (int i = 0; i < 6; i++) if (sel == (6'b000001 << i)) cap[i] = seg;
      end
      for (int i = 0; i < 6; i++) check($sformatf("%s_d%0d", nm, i), 32'(cap[i]), 32'(exp[8*i +: 8]));
   endtask

   initial begin
      repeat (5) @(negedge sys_clk);
      #1 sys_rst_n = 1'b1;
      capture_digits("after_reset", {8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hC0, 8'hC0});

      apply_and_wait(1234, 0);
      capture_digits("v1234", {8'hFF, 8'hFF, 8'h79, 8'hA4, 8'hB0, 8'h99});
      apply_and_wait(5000, 1);
      capture_digits("v5000_neg", {8'hBF, 8'hFF, 8'h12, 8'hC0, 8'hC0, 8'hC0});
      apply_and_wait(0, 1);
      capture_digits("v0_neg", {8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hC0, 8'hC0});
      apply_and_wait(65535, 0);
      capture_digits("v65535", {8'hFF, 8'h82, 8'h12, 8'h92, 8'hB0, 8'h92});

      // Input changes right after the latch must not disturb the conversion in flight
      volt = 16'd1234; sign = 1'b0;
      wait_latch();
      #1 volt = 16'd4321;
      wait_update();
      capture_digits("late_change", {8'hFF, 8'hFF, 8'h79, 8'hA4, 8'hB0, 8'h99});
      wait_update();
      capture_digits("v4321", {8'hFF, 8'hFF, 8'h19, 8'hB0, 8'hA4, 8'hF9});

      // Reset in the middle of a conversion
      volt = 16'd777;
      wait_latch();
      repeat (7) @(negedge sys_clk);
      #1 sys_rst_n = 1'b0;
      #1;
      check("rst_sel", 32'(sel), 32'h01);
      check("rst_seg", 32'(seg), 32'hFF);
      repeat (3) @(negedge sys_clk);
      #1 sys_rst_n = 1'b1;
      capture_digits("after_abort", {8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hC0, 8'hC0});

      for (int it = 0; it < 25; it++) begin
         int v;
         v = (it % 6 == 0) ? 0 : (it % 6 == 1) ? 65535 : int'($urandom_range(0, 65535));
         apply_and_wait(v, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 30)) @(negedge sys_clk);
         #1 volt = 16'($urandom_range(0, 65535));
      end

      repeat (10) @(negedge sys_clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d passed so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
